sync_fifo_prog: RTL

Parametrised synchronous FIFO that generalises the team's single-clock FIFO. It adds:
- non-power-of-2 depth;
- a selectable first-word-fall-through (FWFT) read mode;
- run-time programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- a read-data-valid strobe.

It sits between a producer and a consumer in the same clock domain and is the drop-in buffer for datapath blocks.

---
 rtl/fifo_prog_pack.sv | 16 +
 rtl/fifo_prog_mem.sv | 40 ++++
 rtl/sync_fifo_prog.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_prog_pack.sv
// Shared constants and types for the programmable synchronous FIFO.
// Default geometry plus the read-mode encoding used by instantiating blocks.
package fifo_prog_pack;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W_DEF      = $clog2(FIFO_DEPTH_DEF + 1);

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    typedef logic [CNT_W_DEF-1:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_prog_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// WRITE_FIRST forwards same-address write data onto the read register.
module fifo_prog_mem #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 8,
    parameter bit WRITE_FIRST = 1'b0,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            if (WRITE_FIRST && we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through,
// programmable almost-full/almost-empty thresholds, flush and read-valid.
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = fifo_prog_pack::FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = fifo_prog_pack::FIFO_DEPTH_DEF,
    parameter int FWFT       = 0,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam bit FWFT_MODE = (FWFT == int'(fifo_prog_pack::FWFT));

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             rd_acc;
    logic             wr_acc;
    logic             mem_we;
    logic             mem_re;
    logic [PTR_W-1:0] mem_raddr;

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = (count >= af_thresh);
    assign almostempty = (count <= ae_thresh);

    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_en);

    always_comb begin
        rd_ptr_nxt = rd_acc ? ptr_inc(rd_ptr) : rd_ptr;
        count_nxt  = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_valid  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            wr_ack    <= wr_acc;
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
            rd_valid  <= FWFT_MODE ? (count_nxt != '0) : rd_acc;
        end
    end

    // FWFT prefetches the post-edge head every cycle; a write landing on
    // that slot is forwarded so a word entering an empty FIFO shows at once.
    assign mem_we    = wr_acc & ~flush;
    assign mem_re    = FWFT_MODE ? ~flush : (rd_acc & ~flush);
    assign mem_raddr = FWFT_MODE ? rd_ptr_nxt : rd_ptr;

    fifo_prog_mem #(
        .WIDTH       (FIFO_WIDTH),
        .DEPTH       (FIFO_DEPTH),
        .WRITE_FIRST (FWFT_MODE),
        .ADDR_W      (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (data_out)
    );

endmodule
